// File: rtl/predistort_taps_table.sv
// Predistortion lookup with a double-buffered tap table loaded from the taps stream.
// A new table only becomes active between data packets, so a packet never mixes tables.
//
// state        | meaning
// ST_IDLE      | waiting for the first tap of a table
// ST_LOAD      | writing taps into the shadow bank
// ST_WAIT_SWAP | full table received, waiting for a packet boundary to swap banks
module predistort_taps_table #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] taps_tdata,
  input  logic             taps_tlast,
  input  logic             taps_tvalid,
  output logic             taps_tready,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             taps_loaded,
  output logic             load_error,
  output logic [DEPTH:0]   load_count
);

  localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_SWAP} state_t;

  state_t            state, state_nx;
  logic [DEPTH:0]    cnt, cnt_inc;
  logic              active_bank, in_pkt;
  logic              tap_beat, load_ok, swap_go, stall, i_beat, we;
  logic [DEPTH-1:0]  rd_idx;

  logic [WIDTH-1:0]  bank0 [2**DEPTH];
  logic [WIDTH-1:0]  bank1 [2**DEPTH];
  logic [WIDTH-1:0]  rd_q;
  logic              s1_valid, s1_last, s1_bypass;
  logic [WIDTH-1:0]  s1_data;

  // cnt doubles as the write pointer; it saturates so oversized loads still report a length
  assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
  assign tap_beat = taps_tvalid & taps_tready;
  assign load_ok  = (cnt_inc == FULL);
  assign stall    = o_tvalid & ~o_tready;
  assign i_tready = ~stall & ~swap_go;
  assign i_beat   = i_tvalid & i_tready;
  assign we       = tap_beat & ~clear & ~cnt[DEPTH];
  assign rd_idx   = i_tdata[WIDTH-1 -: DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_LOAD: begin
        if (tap_beat) begin
          if (taps_tlast) state_nx = load_ok ? ST_WAIT_SWAP : ST_IDLE;
          else            state_nx = ST_LOAD;
        end
      end
      ST_WAIT_SWAP: if (swap_go) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
    if (clear) state_nx = ST_IDLE;
  end

  always_comb begin
    taps_tready = (state != ST_WAIT_SWAP);
    swap_go     = (state == ST_WAIT_SWAP) & ~in_pkt & ~clear;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      load_count  <= '0;
      load_error  <= 1'b0;
      taps_loaded <= 1'b0;
      active_bank <= 1'b0;
      in_pkt      <= 1'b0;
    end else begin
      if (clear)         cnt <= '0;
      else if (tap_beat) cnt <= taps_tlast ? '0 : cnt_inc;
      if (tap_beat & taps_tlast & ~clear) begin
        load_count <= cnt_inc;
        load_error <= ~load_ok;
      end
      if (swap_go) begin
        active_bank <= ~active_bank;
        taps_loaded <= 1'b1;
      end
      if (i_beat) in_pkt <= ~i_tlast;
    end
  end

  // Loads always target the inactive bank, so a write never races a lookup read
  always_ff @(posedge clk) begin
    if (we) begin
      if (active_bank) bank0[cnt[DEPTH-1:0]] <= taps_tdata;
      else             bank1[cnt[DEPTH-1:0]] <= taps_tdata;
    end
    if (i_beat) rd_q <= active_bank ? bank1[rd_idx] : bank0[rd_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_bypass <= 1'b0;
      s1_data   <= '0;
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      o_tdata   <= '0;
    end else if (!stall) begin
      s1_valid <= i_beat;
      if (i_beat) begin
        s1_last   <= i_tlast;
        s1_bypass <= ~taps_loaded;
        s1_data   <= i_tdata;
      end
      o_tvalid <= s1_valid;
      if (s1_valid) begin
        o_tlast <= s1_last;
        o_tdata <= s1_bypass ? s1_data : rd_q;
      end
    end
  end

endmodule

// File: tb/tb_predistort_taps_table.sv
// Bench for predistort_taps_table: directed table loads plus randomized lookups
// checked in order against a table-lookup reference with backpressure.
module tb_predistort_taps_table;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int NT    = 1 << DEPTH;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] taps_tdata = '0;
  logic             taps_tlast = 1'b0;
  logic             taps_tvalid = 1'b0;
  logic             taps_tready;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tlast = 1'b0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready = 1'b1;
  logic             taps_loaded;
  logic             load_error;
  logic [DEPTH:0]   load_count;

  always #5 clk = ~clk;

  predistort_taps_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .taps_tdata(taps_tdata), .taps_tlast(taps_tlast), .taps_tvalid(taps_tvalid), .taps_tready(taps_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .taps_loaded(taps_loaded), .load_error(load_error), .load_count(load_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference: the table the spec says is active, or bypass before any commit
  logic [WIDTH-1:0] exp_tab [NT];
  bit               exp_loaded = 0;

  function automatic logic [WIDTH-1:0] ref_lookup(input logic [WIDTH-1:0] d);
    int idx;
    idx = int'(d) / (1 << (WIDTH - DEPTH));
    return exp_loaded ? exp_tab[idx] : d;
  endfunction

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
    int               t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   lat_chk = 1;
  bit   bp_en = 0;
  bit   force_stall = 0;

  initial begin
    logic             prev_stall;
    logic [WIDTH-1:0] prev_d;
    logic             prev_l;
    exp_t             e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", o_tvalid, 1);
          check_eq("hold_data", o_tdata, prev_d);
          check_eq("hold_last", o_tlast, prev_l);
        end
        if (o_tvalid && o_tready) begin
          if (q.size() == 0) check_eq("unexpected_out", 1, 0);
          else begin
            e = q.pop_front();
            check_eq("o_tdata", o_tdata, e.d);
            check_eq("o_tlast", o_tlast, e.l);
            if (lat_chk) check_eq("latency", cyc - e.t, 2);
          end
        end
        if (i_tvalid && i_tready) q.push_back('{ref_lookup(i_tdata), i_tlast, cyc});
        prev_stall = o_tvalid && !o_tready;
        prev_d = o_tdata;
        prev_l = o_tlast;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (force_stall) o_tready = 1'b0;
      else if (bp_en)  o_tready = 1'($urandom_range(0, 1));
      else             o_tready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
    int to;
    to = 0;
    i_tdata = d;
    i_tlast = l;
    i_tvalid = 1'b1;
    @(negedge clk);
    while (!i_tready && to < 200) begin
      to++;
      @(negedge clk);
    end
    if (!i_tready) check_eq("i_tready_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
  endtask

  task automatic load_taps(input logic [WIDTH-1:0] base, input int n, input bit with_last);
    int to;
    for (int k = 0; k < n; k++) begin
      taps_tdata = base + WIDTH'(k);
      taps_tlast = with_last && (k == n - 1);
      taps_tvalid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!taps_tready && to < 200) begin
        to++;
        @(negedge clk);
      end
      if (!taps_tready) check_eq("taps_tready_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    taps_tvalid = 1'b0;
    taps_tlast = 1'b0;
  endtask

  task automatic drain();
    int to;
    to = 0;
    while (q.size() != 0 && to < 1000) begin
      to++;
      @(negedge clk);
    end
    check_eq("drain_empty", q.size(), 0);
    tick(1);
  endtask

  task automatic set_table(input logic [WIDTH-1:0] base);
    for (int k = 0; k < NT; k++) exp_tab[k] = base + WIDTH'(k);
    exp_loaded = 1;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_o_tvalid", o_tvalid, 0);
    check_eq("rst_o_tdata", o_tdata, 0);
    check_eq("rst_o_tlast", o_tlast, 0);
    check_eq("rst_taps_loaded", taps_loaded, 0);
    check_eq("rst_load_error", load_error, 0);
    check_eq("rst_load_count", load_count, 0);
    check_eq("rst_taps_tready", taps_tready, 1);
    check_eq("rst_i_tready", i_tready, 1);
    tick(1);

    send_beat(16'h3456, 1'b1);
    drain();
    check_eq("bypass_taps_loaded", taps_loaded, 0);

    load_taps(16'h1000, 16, 1);
    tick(3);
    set_table(16'h1000);
    check_eq("load1_taps_loaded", taps_loaded, 1);
    check_eq("load1_count", load_count, 16);
    check_eq("load1_error", load_error, 0);
    send_beat(16'h3000, 1'b0);
    send_beat(16'hF123, 1'b1);
    drain();

    load_taps(16'h7000, 10, 1);
    tick(3);
    check_eq("short_error", load_error, 1);
    check_eq("short_count", load_count, 10);
    check_eq("short_taps_loaded", taps_loaded, 1);
    load_taps(16'h7100, 20, 1);
    tick(3);
    check_eq("long_error", load_error, 1);
    check_eq("long_count", load_count, 20);
    send_beat(16'h5555, 1'b1);
    send_beat(16'hE001, 1'b1);
    drain();

    for (int i = 0; i < 3; i++) send_beat(WIDTH'($urandom), 1'b0);
    load_taps(16'h2000, 16, 1);
    tick(2);
    check_eq("midpkt_taps_tready", taps_tready, 0);
    check_eq("midpkt_taps_loaded", taps_loaded, 1);
    check_eq("midpkt_count", load_count, 16);
    for (int i = 3; i < 8; i++) send_beat(WIDTH'($urandom), i == 7);
    @(negedge clk);
    check_eq("swap_bubble_i_tready", i_tready, 0);
    check_eq("swap_bubble_taps_tready", taps_tready, 0);
    @(negedge clk);
    check_eq("post_swap_i_tready", i_tready, 1);
    check_eq("post_swap_taps_tready", taps_tready, 1);
    set_table(16'h2000);
    tick(1);
    for (int i = 0; i < 4; i++) send_beat(WIDTH'($urandom), i == 3);
    drain();

    lat_chk = 0;
    bp_en = 1;
    for (int i = 0; i < 1000; i++)
      send_beat(WIDTH'($urandom), ($urandom_range(0, 7) == 0) || (i == 999));
    drain();
    bp_en = 0;
    tick(2);
    lat_chk = 1;

    force_stall = 1;
    tick(1);
    send_beat(16'hBEEF, 1'b1);
    load_taps(16'h6000, 7, 0);
    check_eq("pre_rst_stalled_valid", o_tvalid, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midload_rst_o_tvalid", o_tvalid, 0);
    check_eq("midload_rst_o_tdata", o_tdata, 0);
    check_eq("midload_rst_o_tlast", o_tlast, 0);
    check_eq("midload_rst_taps_loaded", taps_loaded, 0);
    check_eq("midload_rst_load_count", load_count, 0);
    check_eq("midload_rst_load_error", load_error, 0);
    tick(1);
    exp_loaded = 0;
    force_stall = 0;
    reset = 1'b0;
    tick(2);
    check_eq("after_rst_taps_tready", taps_tready, 1);
    send_beat(16'hABCD, 1'b0);
    send_beat(16'h0123, 1'b1);
    drain();
    check_eq("after_rst_taps_loaded", taps_loaded, 0);

    load_taps(16'h4000, 7, 0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    load_taps(16'h5000, 16, 1);
    tick(3);
    set_table(16'h5000);
    check_eq("clear_count", load_count, 16);
    check_eq("clear_error", load_error, 0);
    check_eq("clear_taps_loaded", taps_loaded, 1);
    for (int i = 0; i < 6; i++) send_beat(WIDTH'($urandom), i == 5);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/predistort_taps_table.md
# predistort_taps_table

Receiving end of the predistortion taps config stream and the lookup engine that consumes it. Accepts the 17-bit taps stream (16-bit tap plus a last flag), produced per channel by the settings-register FIFO in the predistortion NoC block, into a double-buffered table. Maps input magnitudes to predistorted magnitudes by table lookup. The active bank swaps only on a data-packet boundary. Instantiated once per channel in the predistortion datapath.

## Interface
Parameters:
- WIDTH, 16, sample/tap width in bits.
- DEPTH, 13, table address bits; table holds 2^DEPTH taps per bank; DEPTH ≤ WIDTH.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; aborts partial load (see Operation).
- taps_tdata  in  WIDTH  tap value.
- taps_tlast  in  1  last tap of table.
- taps_tvalid  in  1  tap valid.
- taps_tready  out  1  tap accepted when valid&ready.
- i_tdata  in  WIDTH  input magnitude (unsigned).
- i_tlast  in  1  end of data packet.
- i_tvalid  in  1
- i_tready  out  1
- o_tdata  out  WIDTH  predistorted magnitude.
- o_tlast  out  1  delayed i_tlast.
- o_tvalid  out  1
- o_tready  in  1
- taps_loaded  out  1  at least one table committed.
- load_error  out  1  sticky; last load had wrong length.
- load_count  out  DEPTH+1  beats received in last completed load.

## Operation
- Two RAM banks, each 2^DEPTH x WIDTH. active_bank serves lookups. Loads write the other (shadow) bank.
- Lookup index is i_tdata[WIDTH-1:WIDTH-DEPTH].
- Output select:
  - o_tdata = active[index] when taps_loaded=1.
  - o_tdata = i_tdata (bypass) when taps_loaded=0.
- Load FSM states:
  - IDLE: taps_tready=1. First accepted beat writes shadow[0], sets wptr=1, goes to LOAD. If that beat has tlast, go straight to the end-of-load check.
  - LOAD: taps_tready=1. Each beat writes shadow[wptr] and increments wptr. Beats with wptr ≥ 2^DEPTH are dropped but still counted (count saturates at 2^(DEPTH+1)-1). End-of-load check on the tlast beat:
    - Count == 2^DEPTH: load_error<=0, go to WAIT_SWAP.
    - Otherwise: load_error<=1, go to IDLE; active bank and taps_loaded unchanged.
    - load_count always updates with the final count.
  - WAIT_SWAP: taps_tready=0.
    - If in_pkt=1, wait.
    - If in_pkt=0, force i_tready=0 for that cycle. At the edge, toggle active_bank, set taps_loaded<=1, go to IDLE.
- in_pkt:
  - Set on an accepted input beat with i_tlast=0.
  - Cleared on an accepted beat with i_tlast=1.
  - Guarantees every packet uses a single bank.
- clear: FSM->IDLE, wptr->0. Banks, active_bank, taps_loaded, load_error and the lookup pipeline are untouched.
- Reset values:
  - FSM=IDLE, wptr=0, active_bank=0, in_pkt=0.
  - taps_loaded=0, load_error=0, load_count=0.
  - o_tvalid=0, o_tlast=0, o_tdata=0.
  - taps_tready=1 after reset deasserts.
  - RAM contents not reset.
- Reset mid-load: partial shadow contents are discarded; the table is not loaded.

## Timing
- Lookup pipeline, 2 stages:
  - S1: registered RAM read, with the bank select and bypass flag captured at acceptance.
  - S2: output register.
- Latency: an input accepted at cycle N appears on o_tdata at cycle N+2 when o_tready=1 throughout.
- Throughput: 1 sample/cycle.
- Handshake:
  - stall = o_tvalid & ~o_tready.
  - i_tready = ~stall, except for the forced-low swap cycle.
  - On stall both stages hold (RAM read enable gated). No data loss or duplication.
  - o_tvalid, o_tdata and o_tlast are stable while o_tvalid=1 and o_tready=0.
- A load write and a lookup read of the same address never collide: they hit different banks.
- The swap costs exactly one bubble cycle on i_tready.
- Swap to the new bank is visible to a beat accepted in the cycle after the swap edge.

## Test plan
Bench uses WIDTH=16, DEPTH=4.
- Reset, no taps loaded; send 0x3456 -> o_tdata=0x3456 two cycles later, taps_loaded=0.
- Load 16 taps 0x1000+n (tlast on 16th) -> taps_loaded=1, load_count=16, load_error=0; input 0x3000 -> 0x1003, input 0xF123 -> 0x100F, latency 2.
- Load 10 taps -> load_error=1, load_count=10, taps_loaded unchanged. Load 20 taps -> load_error=1, load_count=20, previous table still used.
- Start a 8-beat data packet, load a new table (0x2000+n) mid-packet -> all 8 outputs use the old table, taps_tready=0 until the packet ends, one i_tready bubble, next packet uses 0x2000+n.
- Random o_tready backpressure (50%) over 1000 beats -> output sequence equals the reference lookup in order, no drops, o_tdata stable during stalls.
- Assert reset after 7 of 16 taps -> all outputs take reset values, taps_loaded=0, and lookups bypass.
- Assert clear after 7 of 16 taps, then load 16 fresh taps -> load_count=16, load_error=0, new table active.
